// File: rtl/arch_state_checker_pkg.sv
`default_nettype none
// ============================================================================
// Module   : chk_pkg
// Brief    : Shared types, helpers and default sizes for arch_state_checker.
// Revision : 1.0 - initial release
// ============================================================================
package chk_pkg;

    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_DRAIN    = 3'd1,
        ST_SCAN_REG = 3'd2,
        ST_SCAN_MEM = 3'd3,
        ST_DONE     = 3'd4
    } chk_state_e;

    // Widths never collapse to zero, so single-entry scans still get a 1-bit index.
    function automatic int clog2_min1(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int AREG_NUM_DEF  = 8;
    localparam int MEM_DEPTH_DEF = 4;
    localparam int IDX_W         = clog2_min1(max2(AREG_NUM_DEF, MEM_DEPTH_DEF));
    localparam int ERR_W         = clog2_min1(AREG_NUM_DEF + MEM_DEPTH_DEF + 1);

endpackage
`default_nettype wire

// File: rtl/arch_state_checker_err_log.sv
`default_nettype none
// ============================================================================
// Module   : chk_err_log
// Brief    : Mismatch counter with first-mismatch capture.
// Revision : 1.0 - initial release
// ============================================================================
module chk_err_log
    import chk_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int IDX_W  = chk_pkg::IDX_W,
    parameter int ERR_W  = chk_pkg::ERR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mis_vld_i,
    input  logic              mis_is_mem_i,
    input  logic [IDX_W-1:0]  mis_idx_i,
    input  logic [DATA_W-1:0] mis_got_i,
    input  logic [DATA_W-1:0] mis_exp_i,
    output logic [ERR_W-1:0]  err_cnt_o,
    output logic              first_vld_o,
    output logic              first_is_mem_o,
    output logic [IDX_W-1:0]  first_idx_o,
    output logic [DATA_W-1:0] first_got_o,
    output logic [DATA_W-1:0] first_exp_o
);

    logic [ERR_W-1:0]  r_err_cnt;
    logic              r_first_vld;
    logic              r_first_is_mem;
    logic [IDX_W-1:0]  r_first_idx;
    logic [DATA_W-1:0] r_first_got;
    logic [DATA_W-1:0] r_first_exp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_cnt      <= '0;
            r_first_vld    <= 1'b0;
            r_first_is_mem <= 1'b0;
            r_first_idx    <= '0;
            r_first_got    <= '0;
            r_first_exp    <= '0;
        end else if (mis_vld_i) begin
            r_err_cnt <= r_err_cnt + ERR_W'(1);
            if (!r_first_vld) begin
                r_first_vld    <= 1'b1;
                r_first_is_mem <= mis_is_mem_i;
                r_first_idx    <= mis_idx_i;
                r_first_got    <= mis_got_i;
                r_first_exp    <= mis_exp_i;
            end
        end
    end

    assign err_cnt_o      = r_err_cnt;
    assign first_vld_o    = r_first_vld;
    assign first_is_mem_o = r_first_is_mem;
    assign first_idx_o    = r_first_idx;
    assign first_got_o    = r_first_got;
    assign first_exp_o    = r_first_exp;

endmodule
`default_nettype wire

// File: rtl/arch_state_checker.sv
`default_nettype none
// ============================================================================
// Module   : arch_state_checker
// Brief    : End-of-run architectural register and data-memory state checker.
// Revision : 1.0 - initial release
// ============================================================================
module arch_state_checker
    import chk_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int AREG_NUM    = AREG_NUM_DEF,
    parameter int PTAG_W      = 4,
    parameter int MEM_DEPTH   = MEM_DEPTH_DEF,
    parameter int DRAIN_CYC   = 4,
    parameter int TIMEOUT_CYC = 100000,
    parameter int CYC_W       = 32
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              stop_i,
    output logic [clog2_min1(AREG_NUM)-1:0]                   map_addr_o,
    input  logic [PTAG_W-1:0]                                 map_ptag_i,
    output logic [PTAG_W-1:0]                                 prf_addr_o,
    input  logic [DATA_W-1:0]                                 prf_data_i,
    output logic [clog2_min1(MEM_DEPTH)-1:0]                  mem_addr_o,
    input  logic [DATA_W-1:0]                                 mem_data_i,
    input  logic [DATA_W-1:0]                                 ref_reg_data_i,
    input  logic [DATA_W-1:0]                                 ref_mem_data_i,
    output logic                                              busy_o,
    output logic                                              done_o,
    output logic                                              pass_o,
    output logic                                              timeout_o,
    output logic [clog2_min1(AREG_NUM+MEM_DEPTH+1)-1:0]       err_cnt_o,
    output logic                                              first_err_vld_o,
    output logic                                              first_err_is_mem_o,
    output logic [clog2_min1(max2(AREG_NUM, MEM_DEPTH))-1:0]  first_err_idx_o,
    output logic [DATA_W-1:0]                                 first_err_got_o,
    output logic [DATA_W-1:0]                                 first_err_exp_o,
    output logic [CYC_W-1:0]                                  stop_cyc_o
);

    localparam int c_map_w = clog2_min1(AREG_NUM);
    localparam int c_mem_w = clog2_min1(MEM_DEPTH);
    localparam int c_idx_w = clog2_min1(max2(AREG_NUM, MEM_DEPTH));
    localparam int c_err_w = clog2_min1(AREG_NUM + MEM_DEPTH + 1);
    localparam int c_drn_w = clog2_min1(DRAIN_CYC + 1);

    chk_state_e        r_state;
    chk_state_e        w_state_nxt;
    logic [CYC_W-1:0]  r_cyc_cnt;
    logic [CYC_W-1:0]  r_stop_cyc;
    logic [c_drn_w-1:0] r_drain_cnt;
    logic [c_idx_w-1:0] r_idx;
    logic              r_timeout;
    logic              r_done;

    logic              w_cyc_last;
    logic              w_reg_last;
    logic              w_mem_last;
    logic              w_mis;
    logic              w_mis_is_mem;
    logic [DATA_W-1:0] w_mis_got;
    logic [DATA_W-1:0] w_mis_exp;

    // Compare result is registered before it reaches the log, hence done one edge after the last compare.
    logic              r_mis_vld;
    logic              r_mis_is_mem;
    logic [c_idx_w-1:0] r_mis_idx;
    logic [DATA_W-1:0] r_mis_got;
    logic [DATA_W-1:0] r_mis_exp;

    assign w_cyc_last = (r_cyc_cnt == CYC_W'(TIMEOUT_CYC - 1));
    assign w_reg_last = (r_idx == c_idx_w'(AREG_NUM - 1));
    assign w_mem_last = (r_idx == c_idx_w'(MEM_DEPTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_RUN;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                if (stop_i)          w_state_nxt = (DRAIN_CYC == 0) ? ST_SCAN_REG : ST_DRAIN;
                else if (w_cyc_last) w_state_nxt = ST_DONE;
            end
            ST_DRAIN:    if (r_drain_cnt == c_drn_w'(1)) w_state_nxt = ST_SCAN_REG;
            ST_SCAN_REG: if (w_reg_last) w_state_nxt = ST_SCAN_MEM;
            ST_SCAN_MEM: if (w_mem_last) w_state_nxt = ST_DONE;
            default:     w_state_nxt = r_state;
        endcase
    end

    always_comb begin
        map_addr_o   = '0;
        mem_addr_o   = '0;
        busy_o       = 1'b0;
        w_mis        = 1'b0;
        w_mis_is_mem = 1'b0;
        w_mis_got    = '0;
        w_mis_exp    = '0;
        case (r_state)
            ST_DRAIN: busy_o = 1'b1;
            ST_SCAN_REG: begin
                busy_o     = 1'b1;
                map_addr_o = r_idx[c_map_w-1:0];
                w_mis_got  = prf_data_i;
                w_mis_exp  = ref_reg_data_i;
                w_mis      = (prf_data_i != ref_reg_data_i);
            end
            ST_SCAN_MEM: begin
                busy_o       = 1'b1;
                mem_addr_o   = r_idx[c_mem_w-1:0];
                w_mis_is_mem = 1'b1;
                w_mis_got    = mem_data_i;
                w_mis_exp    = ref_mem_data_i;
                w_mis        = (mem_data_i != ref_mem_data_i);
            end
            // Still busy while the final compare drains through the log.
            ST_DONE: busy_o = !r_done;
            default: busy_o = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cyc_cnt    <= '0;
            r_stop_cyc   <= '0;
            r_drain_cnt  <= '0;
            r_idx        <= '0;
            r_timeout    <= 1'b0;
            r_done       <= 1'b0;
            r_mis_vld    <= 1'b0;
            r_mis_is_mem <= 1'b0;
            r_mis_idx    <= '0;
            r_mis_got    <= '0;
            r_mis_exp    <= '0;
        end else begin
            r_mis_vld    <= w_mis;
            r_mis_is_mem <= w_mis_is_mem;
            r_mis_idx    <= r_idx;
            r_mis_got    <= w_mis_got;
            r_mis_exp    <= w_mis_exp;
            case (r_state)
                ST_RUN: begin
                    r_cyc_cnt <= r_cyc_cnt + CYC_W'(1);
                    if (stop_i) begin
                        r_stop_cyc  <= r_cyc_cnt;
                        r_drain_cnt <= c_drn_w'(DRAIN_CYC);
                    end else if (w_cyc_last) begin
                        r_timeout <= 1'b1;
                        r_done    <= 1'b1;
                    end
                end
                ST_DRAIN:    r_drain_cnt <= r_drain_cnt - c_drn_w'(1);
                ST_SCAN_REG: r_idx <= w_reg_last ? '0 : r_idx + c_idx_w'(1);
                ST_SCAN_MEM: r_idx <= w_mem_last ? '0 : r_idx + c_idx_w'(1);
                ST_DONE:     r_done <= 1'b1;
                default:     r_idx <= '0;
            endcase
        end
    end

    chk_err_log #(
        .DATA_W (DATA_W),
        .IDX_W  (c_idx_w),
        .ERR_W  (c_err_w)
    ) u_err_log (
        .clk            (clk),
        .rst            (rst),
        .mis_vld_i      (r_mis_vld),
        .mis_is_mem_i   (r_mis_is_mem),
        .mis_idx_i      (r_mis_idx),
        .mis_got_i      (r_mis_got),
        .mis_exp_i      (r_mis_exp),
        .err_cnt_o      (err_cnt_o),
        .first_vld_o    (first_err_vld_o),
        .first_is_mem_o (first_err_is_mem_o),
        .first_idx_o    (first_err_idx_o),
        .first_got_o    (first_err_got_o),
        .first_exp_o    (first_err_exp_o)
    );

    assign prf_addr_o = map_ptag_i;
    assign done_o     = r_done;
    assign timeout_o  = r_timeout;
    assign pass_o     = r_done && !r_timeout && (err_cnt_o == '0);
    assign stop_cyc_o = r_stop_cyc;

endmodule
`default_nettype wire

// File: tb/tb_arch_state_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_arch_state_checker
// Brief    : Scoreboard bench: default instance plus a wide/no-drain/short-timeout instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_arch_state_checker;

    typedef struct {
        int          done_edge;
        logic [5:0]  err;
        logic        pass;
        logic        tmo;
        logic        fv;
        logic        fmem;
        logic [4:0]  fidx;
        logic [15:0] fgot;
        logic [15:0] fexp;
        logic [31:0] stop_cyc;
    } exp_t;

    logic clk = 1'b0;
    int   tb_cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) tb_cyc <= tb_cyc + 1;

    // Instance A: default parameters
    logic        rst_a, stop_a;
    logic [2:0]  map_addr_a;
    logic [3:0]  map_ptag_a, prf_addr_a;
    logic [15:0] prf_data_a, mem_data_a, ref_reg_a, ref_mem_a;
    logic [1:0]  mem_addr_a;
    logic        busy_a, done_a, pass_a, timeout_a, fv_a, fmem_a;
    logic [3:0]  err_a;
    logic [2:0]  fidx_a;
    logic [15:0] fgot_a, fexp_a;
    logic [31:0] stopc_a;
    logic [3:0]  map_tbl_a [8];
    logic [15:0] prf_tbl_a [16];
    logic [15:0] rref_tbl_a [8];
    logic [15:0] mem_tbl_a [4];
    logic [15:0] mref_tbl_a [4];

    assign map_ptag_a = map_tbl_a[map_addr_a];
    assign prf_data_a = prf_tbl_a[prf_addr_a];
    assign ref_reg_a  = rref_tbl_a[map_addr_a];
    assign mem_data_a = mem_tbl_a[mem_addr_a];
    assign ref_mem_a  = mref_tbl_a[mem_addr_a];

    arch_state_checker u_a (
        .clk(clk), .rst(rst_a), .stop_i(stop_a),
        .map_addr_o(map_addr_a), .map_ptag_i(map_ptag_a),
        .prf_addr_o(prf_addr_a), .prf_data_i(prf_data_a),
        .mem_addr_o(mem_addr_a), .mem_data_i(mem_data_a),
        .ref_reg_data_i(ref_reg_a), .ref_mem_data_i(ref_mem_a),
        .busy_o(busy_a), .done_o(done_a), .pass_o(pass_a), .timeout_o(timeout_a),
        .err_cnt_o(err_a), .first_err_vld_o(fv_a), .first_err_is_mem_o(fmem_a),
        .first_err_idx_o(fidx_a), .first_err_got_o(fgot_a), .first_err_exp_o(fexp_a),
        .stop_cyc_o(stopc_a)
    );

    // Instance B: no drain, 32 registers, 16 words, short timeout
    logic        rst_b, stop_b;
    logic [4:0]  map_addr_b, map_ptag_b, prf_addr_b;
    logic [15:0] prf_data_b, mem_data_b, ref_reg_b, ref_mem_b;
    logic [3:0]  mem_addr_b;
    logic        busy_b, done_b, pass_b, timeout_b, fv_b, fmem_b;
    logic [5:0]  err_b;
    logic [4:0]  fidx_b;
    logic [15:0] fgot_b, fexp_b;
    logic [31:0] stopc_b;
    logic [4:0]  map_tbl_b [32];
    logic [15:0] prf_tbl_b [32];
    logic [15:0] rref_tbl_b [32];
    logic [15:0] mem_tbl_b [16];
    logic [15:0] mref_tbl_b [16];

    assign map_ptag_b = map_tbl_b[map_addr_b];
    assign prf_data_b = prf_tbl_b[prf_addr_b];
    assign ref_reg_b  = rref_tbl_b[map_addr_b];
    assign mem_data_b = mem_tbl_b[mem_addr_b];
    assign ref_mem_b  = mref_tbl_b[mem_addr_b];

    arch_state_checker #(
        .DATA_W(16), .AREG_NUM(32), .PTAG_W(5), .MEM_DEPTH(16),
        .DRAIN_CYC(0), .TIMEOUT_CYC(20), .CYC_W(32)
    ) u_b (
        .clk(clk), .rst(rst_b), .stop_i(stop_b),
        .map_addr_o(map_addr_b), .map_ptag_i(map_ptag_b),
        .prf_addr_o(prf_addr_b), .prf_data_i(prf_data_b),
        .mem_addr_o(mem_addr_b), .mem_data_i(mem_data_b),
        .ref_reg_data_i(ref_reg_b), .ref_mem_data_i(ref_mem_b),
        .busy_o(busy_b), .done_o(done_b), .pass_o(pass_b), .timeout_o(timeout_b),
        .err_cnt_o(err_b), .first_err_vld_o(fv_b), .first_err_is_mem_o(fmem_b),
        .first_err_idx_o(fidx_b), .first_err_got_o(fgot_b), .first_err_exp_o(fexp_b),
        .stop_cyc_o(stopc_b)
    );

    exp_t q_a[$];
    exp_t q_b[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    function automatic exp_t mk_exp(input int de, input int err, input bit pass, input bit tmo,
                                    input bit fv, input bit fmem, input int fidx,
                                    input int fgot, input int fexp, input int stopc);
        exp_t e;
        e.done_edge = de;
        e.err       = 6'(err);
        e.pass      = pass;
        e.tmo       = tmo;
        e.fv        = fv;
        e.fmem      = fmem;
        e.fidx      = 5'(fidx);
        e.fgot      = 16'(fgot);
        e.fexp      = 16'(fexp);
        e.stop_cyc  = 32'(stopc);
        return e;
    endfunction

    task automatic cmp_done(input string t, input exp_t e, input logic [5:0] err, input logic pass,
                            input logic tmo, input logic fv, input logic fmem, input logic [4:0] fidx,
                            input logic [15:0] fgot, input logic [15:0] fexp, input logic [31:0] stopc);
        chk({t, "_done_edge"}, tb_cyc, e.done_edge);
        chk({t, "_err_cnt"},   err,    e.err);
        chk({t, "_pass"},      pass,   e.pass);
        chk({t, "_timeout"},   tmo,    e.tmo);
        chk({t, "_first_vld"}, fv,     e.fv);
        chk({t, "_first_mem"}, fmem,   e.fmem);
        chk({t, "_first_idx"}, fidx,   e.fidx);
        chk({t, "_first_got"}, fgot,   e.fgot);
        chk({t, "_first_exp"}, fexp,   e.fexp);
        chk({t, "_stop_cyc"},  stopc,  e.stop_cyc);
    endtask

    logic done_a_prev = 1'b0;
    logic done_b_prev = 1'b0;

    always @(negedge clk) begin
        if (done_a && !done_a_prev) begin
            chk("a_exp_avail", q_a.size() != 0, 1'b1);
            if (q_a.size() != 0)
                cmp_done("a", q_a.pop_front(), {2'b0, err_a}, pass_a, timeout_a, fv_a, fmem_a,
                         {2'b0, fidx_a}, fgot_a, fexp_a, stopc_a);
        end
        done_a_prev = done_a;
    end

    always @(negedge clk) begin
        if (done_b && !done_b_prev) begin
            chk("b_exp_avail", q_b.size() != 0, 1'b1);
            if (q_b.size() != 0)
                cmp_done("b", q_b.pop_front(), err_b, pass_b, timeout_b, fv_b, fmem_b,
                         fidx_b, fgot_b, fexp_b, stopc_b);
        end
        done_b_prev = done_b;
    end

    task automatic load_tables_a();
        for (int i = 0; i < 16; i++) prf_tbl_a[i] = 16'hDEAD;
        for (int i = 0; i < 8; i++) begin
            map_tbl_a[i]       = 4'(i + 8);
            prf_tbl_a[i + 8]   = 16'(16'h1000 + i);
            rref_tbl_a[i]      = 16'(16'h1000 + i);
        end
        for (int i = 0; i < 4; i++) begin
            mem_tbl_a[i]  = 16'(16'h2000 + i);
            mref_tbl_a[i] = 16'(16'h2000 + i);
        end
    endtask

    initial begin
        int e0;
        int r0;
        int bad_map;
        int bad_mem;
        bit bad_addr;
        bit bad_busy;

        rst_a = 1'b1; rst_b = 1'b1; stop_a = 1'b0; stop_b = 1'b0;
        load_tables_a();
        for (int i = 0; i < 32; i++) begin
            map_tbl_b[i]        = 5'(31 - i);
            prf_tbl_b[31 - i]   = 16'(16'h3000 + i);
            rref_tbl_b[i]       = 16'(16'h3000 + i);
        end
        for (int i = 0; i < 16; i++) begin
            mem_tbl_b[i]  = 16'(16'h4000 + 3 * i);
            mref_tbl_b[i] = 16'(16'h4000 + 3 * i);
        end
        repeat (3) @(negedge clk);

        chk("rst_busy",     busy_a,     0);
        chk("rst_done",     done_a,     0);
        chk("rst_pass",     pass_a,     0);
        chk("rst_timeout",  timeout_a,  0);
        chk("rst_err_cnt",  err_a,      0);
        chk("rst_stop_cyc", stopc_a,    0);
        chk("rst_map_addr", map_addr_a, 0);

        // All-match run, stop at cycle 50, stop held through DONE
        rst_a = 1'b0;
        repeat (50) @(negedge clk);
        stop_a = 1'b1;
        e0 = tb_cyc + 1;
        q_a.push_back(mk_exp(e0 + 17, 0, 1, 0, 0, 0, 0, 0, 0, 50));
        @(negedge clk);
        chk("a_busy_after_stop", busy_a, 1);
        repeat (26) @(negedge clk);
        chk("a_hold_done",     done_a,  1);
        chk("a_hold_err_cnt",  err_a,   0);
        chk("a_hold_stop_cyc", stopc_a, 50);
        chk("a_hold_busy",     busy_a,  0);
        stop_a = 1'b0;

        // Register 3 and memory word 2 wrong
        rst_a = 1'b1;
        prf_tbl_a[map_tbl_a[3]] = 16'h00AA;
        rref_tbl_a[3]           = 16'h00AB;
        mem_tbl_a[2]            = 16'h5555;
        @(negedge clk);
        rst_a = 1'b0;
        repeat (30) @(negedge clk);
        stop_a = 1'b1;
        e0 = tb_cyc + 1;
        q_a.push_back(mk_exp(e0 + 17, 2, 0, 0, 1, 0, 3, 16'h00AA, 16'h00AB, 30));
        @(negedge clk);
        stop_a = 1'b0;
        repeat (25) @(negedge clk);

        // Reset mid-SCAN_MEM, then a clean run stopped at cycle 10
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        repeat (5) @(negedge clk);
        stop_a = 1'b1;
        @(negedge clk);
        stop_a = 1'b0;
        repeat (13) @(negedge clk);
        chk("a_scan_mem_addr", mem_addr_a, 1);
        chk("a_scan_err_cnt",  err_a,      1);
        #2 rst_a = 1'b1;
        #1;
        chk("a_arst_busy",     busy_a,   0);
        chk("a_arst_err_cnt",  err_a,    0);
        chk("a_arst_first",    fv_a,     0);
        chk("a_arst_got",      fgot_a,   0);
        chk("a_arst_stop_cyc", stopc_a,  0);
        chk("a_arst_mem_addr", mem_addr_a, 0);
        chk("a_arst_done",     done_a,   0);
        load_tables_a();
        @(negedge clk);
        rst_a = 1'b0;
        repeat (10) @(negedge clk);
        stop_a = 1'b1;
        e0 = tb_cyc + 1;
        q_a.push_back(mk_exp(e0 + 17, 0, 1, 0, 0, 0, 0, 0, 0, 10));
        @(negedge clk);
        stop_a = 1'b0;
        repeat (25) @(negedge clk);

        // Instance B: timeout with stop never asserted
        rst_b = 1'b0;
        r0 = tb_cyc;
        q_b.push_back(mk_exp(r0 + 20, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        bad_addr = 1'b0;
        bad_busy = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (map_addr_b != 0 || mem_addr_b != 0) bad_addr = 1'b1;
            if (busy_b) bad_busy = 1'b1;
        end
        chk("b_tmo_addr_zero", bad_addr, 0);
        chk("b_tmo_no_busy",   bad_busy, 0);

        // Instance B: reversed rename mapping, no drain
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        repeat (5) @(negedge clk);
        stop_b = 1'b1;
        e0 = tb_cyc + 1;
        q_b.push_back(mk_exp(e0 + 49, 0, 1, 0, 0, 0, 0, 0, 0, 5));
        @(negedge clk);
        stop_b = 1'b0;
        bad_map = -1;
        for (int i = 0; i < 32; i++) begin
            if ((map_addr_b != 5'(i) || prf_addr_b != 5'(31 - i)) && bad_map < 0) bad_map = i;
            @(negedge clk);
        end
        bad_mem = -1;
        for (int i = 0; i < 16; i++) begin
            if (mem_addr_b != 4'(i) && bad_mem < 0) bad_mem = i;
            @(negedge clk);
        end
        chk("b_map_seq_first_bad", bad_map, -1);
        chk("b_mem_seq_first_bad", bad_mem, -1);
        repeat (5) @(negedge clk);

        chk("a_pending", q_a.size(), 0);
        chk("b_pending", q_b.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/arch_state_checker.md
# arch_state_checker

- Synthesizable end-of-run architectural-state checker; parametrised successor to the fixed 8-register / 4-word end-of-test compare.
- Counts cycles until the core raises its stop (flush) signal, then waits a drain window.
- Scans every architectural register (rename-table lookup, then PRF read) and every data-memory word, comparing each against a reference source.
- Reports pass/fail, mismatch count, first-mismatch detail, stop cycle and timeout; sits beside the core and is usable in simulation and on FPGA.

## Interface

Parameters:
- DATA_W, 16, register/memory word width
- AREG_NUM, 8, architectural registers scanned (≥1)
- PTAG_W, 4, physical-register tag width
- MEM_DEPTH, 4, data-memory words scanned (≥1)
- DRAIN_CYC, 4, wait cycles between stop and scan (≥0)
- TIMEOUT_CYC, 100000, run cycles allowed before forced finish (≥1)
- CYC_W, 32, cycle-counter width

Ports:
- clk, in, 1, single clock
- rst, in, 1, asynchronous active-high reset
- stop_i, in, 1, core stop/flush level
- map_addr_o, out, $clog2(AREG_NUM), architectural index to rename table
- map_ptag_i, in, PTAG_W, physical tag for map_addr_o (combinational)
- prf_addr_o, out, PTAG_W, PRF read address (= map_ptag_i, combinational pass)
- prf_data_i, in, DATA_W, PRF read data (combinational)
- mem_addr_o, out, $clog2(MEM_DEPTH), data-memory word address
- mem_data_i, in, DATA_W, memory read data (combinational)
- ref_reg_data_i, in, DATA_W, expected value for map_addr_o
- ref_mem_data_i, in, DATA_W, expected value for mem_addr_o
- busy_o, out, 1, DRAIN or scan in progress
- done_o, out, 1, check complete (sticky)
- pass_o, out, 1, done with zero mismatches and no timeout
- timeout_o, out, 1, TIMEOUT_CYC reached without stop
- err_cnt_o, out, $clog2(AREG_NUM+MEM_DEPTH+1), mismatch count
- first_err_vld_o, out, 1, first mismatch captured
- first_err_is_mem_o, out, 1, first mismatch in memory (0 = register)
- first_err_idx_o, out, max index width, index of first mismatch
- first_err_got_o / first_err_exp_o, out, DATA_W each, observed/expected at first mismatch
- stop_cyc_o, out, CYC_W, cycle count at which stop was sampled

## Operation

- FSM states: RUN, DRAIN, SCAN_REG, SCAN_MEM, DONE. Reset enters RUN.
- RUN: cyc_cnt increments each cycle.
  - stop_i=1 at an edge: latch stop_cyc_o=cyc_cnt; go to DRAIN (SCAN_REG if DRAIN_CYC=0).
  - Else if cyc_cnt=TIMEOUT_CYC-1: timeout_o=1, go to DONE.
  - stop_i and timeout on the same edge: stop wins.
- DRAIN: down-counter loaded with DRAIN_CYC; leave after DRAIN_CYC cycles.
- SCAN_REG: idx runs 0..AREG_NUM-1, one per cycle.
  - map_addr_o=idx.
  - Compare prf_data_i != ref_reg_data_i combinationally; register the result at the edge.
  - After AREG_NUM-1, go to SCAN_MEM.
- SCAN_MEM: same for mem_addr_o, mem_data_i, ref_mem_data_i over 0..MEM_DEPTH-1; then DONE.
- Each mismatch increments err_cnt_o. No saturation needed: the counter width covers the total.
- First mismatch only: capture is_mem, idx, got, exp; set first_err_vld_o. Later mismatches never overwrite it.
- DONE: absorbing until rst.
  - done_o=1; pass_o = (err_cnt_o==0) && !timeout_o.
  - stop_i is ignored outside RUN.
- Address outputs are 0 outside their scan state.

## Timing

- Reset values: every output 0; stop_cyc_o=0; state RUN; cyc_cnt=0.
- stop sampled at edge E0:
  - busy_o rises after E0.
  - First compare in the cycle after E0+DRAIN_CYC.
  - done_o rises at edge E0+DRAIN_CYC+AREG_NUM+MEM_DEPTH+1 and stays high.
- Timeout: done_o and timeout_o rise at the edge where cyc_cnt equals TIMEOUT_CYC-1; busy_o never rises.
- Read ports are combinational: data must settle within the same cycle as the address.
- rst asserted mid-DRAIN or mid-scan: immediate asynchronous return to the reset state; all results cleared.

## Structure

- Package chk_pkg holds:
  - state enum chk_state_e;
  - IDX_W=$clog2(max(AREG_NUM,MEM_DEPTH));
  - ERR_W=$clog2(AREG_NUM+MEM_DEPTH+1).
- One sub-module, chk_err_log: mismatch counter plus first-error capture, driven by a mismatch strobe and a detail bus.

## Test plan

- Defaults, all registers and memory match, stop at cycle 50 → stop_cyc_o=50, done_o at E0+17, pass_o=1, err_cnt_o=0.
- Register 3 wrong (got 0x00AA, exp 0x00AB) and memory word 2 wrong → err_cnt_o=2, first_err_is_mem_o=0, idx=3, got=0x00AA, exp=0x00AB, pass_o=0.
- stop_i never asserted, TIMEOUT_CYC=20 → timeout_o=1 and done_o at cycle 19; pass_o=0; address outputs stay 0.
- DRAIN_CYC=0, AREG_NUM=32, MEM_DEPTH=16, rename table mapping register i to tag 31-i → PRF addresses follow the mapping; done_o at E0+49.
- rst pulsed during SCAN_MEM, then stop re-asserted at cycle 10 → all outputs back to 0; fresh run reports stop_cyc_o=10.
- stop_i held high through DONE → no re-trigger; err_cnt_o unchanged.
